alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of a shared combinational ALU with a registered response
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (requester 0 always wins ties; no priority pointer)
module alu_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  // requester 0
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  // requester 1
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  // shared combinational ALU
  output logic [3:0]      alu_ctl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  // registered response
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_zero
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic slot_open;
  logic any_valid;
  logic grant;
  logic grant_id;

  // A new operation may issue when nothing is pending or the pending
  // response is being consumed this cycle.
  assign slot_open = (state == IDLE) | rsp_ready;
  assign any_valid = req0_valid | req1_valid;
  // Reset gates the grant so readies and ALU operands stay quiet while rst is high.
  assign grant     = ~rst & slot_open & any_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Requester 1 only wins when requester 0 is not asking.
  assign grant_id = ~req0_valid;
`else
  logic ptr;

  // Requester 1 wins when it is the only one asking, or on a tie when the pointer prefers it.
  assign grant_id = req1_valid & (~req0_valid | ptr);

  // Pointer moves to the requester that did not win, so ties alternate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (grant) begin
      ptr <= ~grant_id;
    end
  end
`endif

  // Next state, grant handshakes and ALU operand steering.
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_ctl    = 4'd0;
    alu_a      = '0;
    alu_b      = '0;
    if (grant) begin
      state_next = RESP;
      if (grant_id) begin
        req1_ready = 1'b1;
        alu_ctl    = req1_op;
        alu_a      = req1_a;
        alu_b      = req1_b;
      end else begin
        req0_ready = 1'b1;
        alu_ctl    = req0_op;
        alu_a      = req0_a;
        alu_b      = req0_b;
      end
    end else if ((state == RESP) && rsp_ready) begin
      state_next = IDLE;
    end
  end

  // State register; reset drops any pending response immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Response capture on the grant edge; held untouched otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_id     <= 1'b0;
    end else if (grant) begin
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      rsp_id     <= grant_id;
    end
  end

  assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized and directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req0_ready;
  logic [3:0]      req0_op;
  logic [XLEN-1:0] req0_a, req0_b;
  logic            req1_valid, req1_ready;
  logic [3:0]      req1_op;
  logic [XLEN-1:0] req1_a, req1_b;
  logic [3:0]      alu_ctl;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic            alu_zero;
  logic            rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [XLEN-1:0] rsp_result;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic            m_rsp;
  logic            m_id;
  logic [XLEN-1:0] m_res;
  logic            m_zero;
  int              pref;
  int              last_grant;

  always #5 clk = ~clk;

  alu_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  function automatic logic [XLEN-1:0] alu_fn(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  // shared ALU driven by the bench
  assign alu_result = alu_fn(alu_ctl, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  function automatic logic [3:0] pick_op();
    case ($urandom_range(5, 0))
      0: return 4'b0000;
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0110;
      4: return 4'b0111;
      default: return 4'b1100;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rsp  = 1'b0;
    m_id   = 1'b0;
    m_res  = '0;
    m_zero = 1'b0;
    pref   = 0;
  endtask

  // One cycle: called just after a falling edge with inputs already driven.
  task automatic step();
    int              win;
    logic            slot;
    logic [3:0]      eop;
    logic [XLEN-1:0] ea, eb;
    #1;
    slot = !m_rsp || rsp_ready;
    win  = -1;
    if (slot) begin
      if (req0_valid && req1_valid) win = pref;
      else if (req0_valid)          win = 0;
      else if (req1_valid)          win = 1;
    end
    eop = 4'd0; ea = '0; eb = '0;
    if (win == 0) begin eop = req0_op; ea = req0_a; eb = req0_b; end
    if (win == 1) begin eop = req1_op; ea = req1_a; eb = req1_b; end
    check_eq("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
    if (m_rsp) begin
      check_eq("rsp_id", 32'(rsp_id), 32'(m_id));
      check_eq("rsp_result", rsp_result, m_res);
      check_eq("rsp_zero", 32'(rsp_zero), 32'(m_zero));
    end
    check_eq("req0_ready", 32'(req0_ready), 32'(win == 0));
    check_eq("req1_ready", 32'(req1_ready), 32'(win == 1));
    check_eq("alu_ctl", 32'(alu_ctl), 32'(eop));
    check_eq("alu_a", alu_a, ea);
    check_eq("alu_b", alu_b, eb);
    last_grant = win;
    @(posedge clk);
    if (win >= 0) begin
      m_rsp  = 1'b1;
      m_id   = (win == 1);
      m_res  = alu_fn(eop, ea, eb);
      m_zero = (m_res == '0);
`ifndef ALU_ARB_FIXED_PRIO_EN
      pref   = 1 - win;
`endif
    end else if (slot) begin
      m_rsp = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int exp_id;
    rst = 1'b1;
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'd3; req1_b = 32'd4;
    rsp_ready  = 1'b1;
    model_reset();
    last_grant = -1;

    // quiet outputs while reset is held, even with requests pending
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_req0_ready", 32'(req0_ready), 32'd0);
    check_eq("rst_req1_ready", 32'(req1_ready), 32'd0);
    check_eq("rst_alu_ctl", 32'(alu_ctl), 32'd0);
    check_eq("rst_alu_a", alu_a, 32'd0);
    check_eq("rst_alu_b", alu_b, 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_result", rsp_result, 32'd0);
    check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;

    // ADD 5+7 from requester 0
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd5; req0_b = 32'd7;
    step();
    req0_valid = 1'b0;
    #1;
    check_eq("add_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("add_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("add_rsp_result", rsp_result, 32'd12);
    check_eq("add_rsp_zero", 32'(rsp_zero), 32'd0);
    step();

    // SUB 9-9 from requester 1 yields zero
    req1_valid = 1'b1; req1_op = 4'b0110; req1_a = 32'd9; req1_b = 32'd9;
    step();
    req1_valid = 1'b0;
    #1;
    check_eq("sub_rsp_id", 32'(rsp_id), 32'd1);
    check_eq("sub_rsp_result", rsp_result, 32'd0);
    check_eq("sub_rsp_zero", 32'(rsp_zero), 32'd1);
    step();

    // both valid every cycle straight after reset
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'(i); req0_b = 32'd100;
      req1_valid = 1'b1; req1_op = 4'b0110; req1_a = 32'd50; req1_b = 32'(i);
      rsp_ready  = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = i % 2;
`endif
      #1;
      check_eq("tie_grant1", 32'(req1_ready), 32'(exp_id == 1));
      check_eq("tie_grant0", 32'(req0_ready), 32'(exp_id == 0));
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // back-pressure holds the response and blocks the waiting requester
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd3; req0_b = 32'd4;
    rsp_ready  = 1'b1;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 4'b0001; req1_a = 32'hF0; req1_b = 32'h0F;
    rsp_ready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("hold_result", rsp_result, 32'd7);
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_req1_ready", 32'(req1_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check_eq("release_req1_ready", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    #1;
    check_eq("release_rsp_id", 32'(rsp_id), 32'd1);
    check_eq("release_rsp_result", rsp_result, 32'hFF);
    step();

    // reset asserted mid-cycle while a response is pending
    req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'd1; req1_b = 32'd1;
    step();
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    #2;
    check_eq("pre_rst_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'hFF; req0_b = 32'h0F;
    req1_valid = 1'b1; req1_op = 4'b0001; req1_a = 32'h10; req1_b = 32'h01;
    #1;
    check_eq("post_rst_no_stale", 32'(rsp_valid), 32'd0);
    check_eq("post_rst_ptr0", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;

    // randomized traffic with random back-pressure
    for (int c = 0; c < 600; c++) begin
      if (!req0_valid && $urandom_range(1, 0) == 1) begin
        req0_valid = 1'b1; req0_op = pick_op(); req0_a = $urandom;
        req0_b = ($urandom_range(3, 0) == 0) ? req0_a : $urandom;
      end
      if (!req1_valid && $urandom_range(1, 0) == 1) begin
        req1_valid = 1'b1; req1_op = pick_op(); req1_a = $urandom;
        req1_b = ($urandom_range(3, 0) == 0) ? req1_a : $urandom;
      end
      rsp_ready = ($urandom_range(3, 0) != 0);
      step();
      if (last_grant == 0) req0_valid = 1'b0;
      if (last_grant == 1) req1_valid = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
